// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with write-to-read bypass
// and a per-register busy scoreboard for hazard detection.
module regfile_mp_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic [1:0]             wr_en,
  input  logic [AW-1:0]          wr_addr0,
  input  logic [WIDTH-1:0]       wr_data0,
  input  logic [AW-1:0]          wr_addr1,
  input  logic [WIDTH-1:0]       wr_data1,
  input  logic                   sb_set,
  input  logic [AW-1:0]          sb_addr,
  output logic [AW:0]            busy_cnt
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busyNext;
  logic [AW:0]      busyCnt;
  logic [AW:0]      cntNext;
  logic             we0;
  logic             we1;

  // Writes to the hardwired zero register are dropped.
  assign we0 = wr_en[0] && !(ZR && wr_addr0 == '0);
  assign we1 = wr_en[1] && !(ZR && wr_addr1 == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs[k] <= '0;
      end
    end else begin
      if (we0) regs[wr_addr0] <= wr_data0;
      if (we1) regs[wr_addr1] <= wr_data1;
    end
  end

  // Set is applied after clears so a newly issued producer wins.
  always_comb begin
    busyNext = busy;
    if (wr_en[0]) busyNext[wr_addr0] = 1'b0;
    if (wr_en[1]) busyNext[wr_addr1] = 1'b0;
    if (sb_set)   busyNext[sb_addr]  = 1'b1;
    if (ZR)       busyNext[0]        = 1'b0;
  end

  always_comb begin
    cntNext = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cntNext = cntNext + (AW+1)'(busyNext[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy    <= '0;
      busyCnt <= '0;
    end else begin
      busy    <= busyNext;
      busyCnt <= cntNext;
    end
  end

  assign busy_cnt = busyCnt;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]    a;
    logic             hit0;
    logic             hit1;
    logic [WIDTH-1:0] d;

    assign a    = rd_addr[i*AW +: AW];
    assign hit0 = wr_en[0] && wr_addr0 == a;
    assign hit1 = wr_en[1] && wr_addr1 == a;

    always_comb begin
      d = regs[a];
      if (ZR && a == '0)        d = '0;
      else if (rst_n && hit1)   d = wr_data1;
      else if (rst_n && hit0)   d = wr_data0;
    end

    assign rd_data[i*WIDTH +: WIDTH] = d;
    // A retiring write is bypassed, so the operand is ready now.
    assign rd_busy[i] = busy[a] & ~(hit0 | hit1);
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard: vector table driven
// through an expected-result queue, plus reset sequences.
module tb_regfile_mp_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [4:0]  wr_addr0;
  logic [31:0] wr_data0;
  logic [4:0]  wr_addr1;
  logic [31:0] wr_data1;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [5:0]  busy_cnt;

  int nTests = 0;
  int nFail  = 0;

  regfile_mp_scoreboard dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr0 (wr_addr0),
    .wr_data0 (wr_data0),
    .wr_addr1 (wr_addr1),
    .wr_data1 (wr_data1),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        sbs;
    logic [4:0]  sba;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] eD0;
    logic [31:0] eD1;
    logic [1:0]  eB;
    logic [5:0]  eCnt;
  } vec_t;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  b;
    logic [5:0]  cnt;
  } exp_t;

  vec_t vt [16];
  exp_t expQ [$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wr_en    = 2'b00;
    wr_addr0 = 5'd0;
    wr_data0 = 32'd0;
    wr_addr1 = 5'd0;
    wr_data1 = 32'd0;
    sb_set   = 1'b0;
    sb_addr  = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    for (int a = 0; a < 32; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      #1;
      check($sformatf("%s_d0_r%0d", tag, a), rd_data[31:0], 32'd0);
      check($sformatf("%s_d1_r%0d", tag, a + 1), rd_data[63:32], 32'd0);
      check($sformatf("%s_busy_r%0d", tag, a), 32'(rd_busy), 32'd0);
    end
  endtask

  initial begin
    exp_t e;
    vt[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0,
               5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 2'b00, 6'd0};
    vt[1]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
               5'd5, 5'd7, 32'hDEADBEEF, 32'd0, 2'b00, 6'd0};
    vt[2]  = '{2'b11, 5'd7, 32'd1, 5'd7, 32'd2, 1'b0, 5'd0,
               5'd5, 5'd7, 32'hDEADBEEF, 32'd2, 2'b00, 6'd0};
    vt[3]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
               5'd7, 5'd5, 32'd2, 32'hDEADBEEF, 2'b00, 6'd0};
    vt[4]  = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 5'd0,
               5'd0, 5'd0, 32'd0, 32'd0, 2'b00, 6'd0};
    vt[5]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
               5'd0, 5'd5, 32'd0, 32'hDEADBEEF, 2'b00, 6'd0};
    vt[6]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9,
               5'd9, 5'd7, 32'd0, 32'd2, 2'b00, 6'd1};
    vt[7]  = '{2'b01, 5'd9, 32'hAAAA5555, 5'd0, 32'd0, 1'b1, 5'd9,
               5'd9, 5'd9, 32'hAAAA5555, 32'hAAAA5555, 2'b00, 6'd1};
    vt[8]  = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
               5'd9, 5'd9, 32'hAAAA5555, 32'hAAAA5555, 2'b11, 6'd1};
    vt[9]  = '{2'b01, 5'd9, 32'h12345678, 5'd0, 32'd0, 1'b0, 5'd0,
               5'd9, 5'd9, 32'h12345678, 32'h12345678, 2'b00, 6'd0};
    vt[10] = '{2'b10, 5'd0, 32'd0, 5'd3, 32'd33, 1'b0, 5'd0,
               5'd3, 5'd9, 32'd33, 32'h12345678, 2'b00, 6'd0};
    vt[11] = '{2'b10, 5'd0, 32'd0, 5'd4, 32'd44, 1'b1, 5'd4,
               5'd4, 5'd3, 32'd44, 32'd33, 2'b00, 6'd1};
    vt[12] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
               5'd4, 5'd4, 32'd44, 32'd44, 2'b11, 6'd1};
    vt[13] = '{2'b10, 5'd0, 32'd0, 5'd4, 32'd45, 1'b0, 5'd0,
               5'd4, 5'd4, 32'd45, 32'd45, 2'b00, 6'd0};
    vt[14] = '{2'b11, 5'd10, 32'hA0, 5'd11, 32'hB1, 1'b0, 5'd0,
               5'd10, 5'd11, 32'hA0, 32'hB1, 2'b00, 6'd0};
    vt[15] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
               5'd11, 5'd10, 32'hB1, 32'hA0, 2'b00, 6'd0};

    idle();
    rd_addr = 10'd0;
    rst_n   = 1'b0;
    tick();
    rst_n = 1'b1;
    check("reset_cnt", 32'(busy_cnt), 32'd0);
    checkAllZero("reset");

    for (int i = 0; i < 16; i++) begin
      wr_en    = vt[i].we;
      wr_addr0 = vt[i].a0;
      wr_data0 = vt[i].d0;
      wr_addr1 = vt[i].a1;
      wr_data1 = vt[i].d1;
      sb_set   = vt[i].sbs;
      sb_addr  = vt[i].sba;
      rd_addr  = {vt[i].ra1, vt[i].ra0};
      expQ.push_back('{vt[i].eD0, vt[i].eD1, vt[i].eB, vt[i].eCnt});
      #2;
      if (expQ.size() == 0) begin
        check($sformatf("v%0d_queue_empty", i), 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        check($sformatf("v%0d_d0", i), rd_data[31:0], e.d0);
        check($sformatf("v%0d_d1", i), rd_data[63:32], e.d1);
        check($sformatf("v%0d_busy", i), 32'(rd_busy), 32'(e.b));
        tick();
        check($sformatf("v%0d_cnt", i), 32'(busy_cnt), 32'(e.cnt));
      end
    end

    idle();
    for (int r = 1; r < 32; r++) begin
      sb_set  = 1'b1;
      sb_addr = 5'(r);
      tick();
    end
    sb_set = 1'b0;
    check("fill_cnt", 32'(busy_cnt), 32'd31);
    rd_addr = {5'd31, 5'd17};
    #1;
    check("fill_busy", 32'(rd_busy), 32'd3);

    rst_n    = 1'b0;
    sb_set   = 1'b1;
    sb_addr  = 5'd8;
    wr_en    = 2'b11;
    wr_addr0 = 5'd5;
    wr_data0 = 32'hFFFF0000;
    wr_addr1 = 5'd6;
    wr_data1 = 32'h0000FFFF;
    rd_addr  = {5'd6, 5'd5};
    #1;
    check("rst_nobyp_d0", rd_data[31:0], 32'hDEADBEEF);
    check("rst_nobyp_d1", rd_data[63:32], 32'd0);
    tick();
    rst_n = 1'b1;
    idle();
    check("rst2_cnt", 32'(busy_cnt), 32'd0);
    checkAllZero("rst2");
    tick();
    check("rst2_cnt_hold", 32'(busy_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
